ofdm_rx_decode_ctrl: RTL and testbench

- Sequences the OFDM decoder chain (demod, deinterleave, viterbi, descramble, bits-to-bytes) through one legacy packet.
- Phases: decode SIGNAL at 6 Mbps with no descrambling; parse and check SIGNAL; reset the decoder; reconfigure it for DATA; count PSDU bytes to completion.
- Sits between the sync/equalizer front end (issues start) and the decoder instance; drives that instance's reset, enable, rate, do_descramble and num_bits_to_decode.

---
 rtl/ofdm_rx_decode_ctrl_pkg.sv | 42 ++++
 rtl/ofdm_rx_decode_ctrl_if.sv | 34 +++
 rtl/ofdm_rx_decode_ctrl_nsym.sv | 50 +++++
 rtl/ofdm_rx_decode_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_ofdm_rx_decode_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/ofdm_rx_decode_ctrl_pkg.sv
// Shared types, constants and the rate lookup for the OFDM RX decode controller.
package ofdm_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SIG_RST,
        SIG_DEC,
        SIG_CHK,
        DATA_RST,
        DATA_DEC
    } state_e;

    localparam logic [3:0]  RATE_6M           = 4'b1011;
    localparam logic [15:0] SERVICE_TAIL_BITS = 16'd22;

    typedef struct packed {
        logic        valid;
        logic [15:0] n_dbps;
        logic [15:0] n_cbps;
    } rate_info_t;

    // Map a SIGNAL rate code to data/coded bits per symbol; valid=0 for unknown codes.
    function automatic rate_info_t rate_lookup(input logic [3:0] rate);
        rate_info_t info;
        info.valid  = 1'b1;
        info.n_dbps = '0;
        info.n_cbps = '0;
        case (rate)
            4'b1011: begin info.n_dbps = 16'd24;  info.n_cbps = 16'd48;  end
            4'b1111: begin info.n_dbps = 16'd36;  info.n_cbps = 16'd48;  end
            4'b1010: begin info.n_dbps = 16'd48;  info.n_cbps = 16'd96;  end
            4'b1110: begin info.n_dbps = 16'd72;  info.n_cbps = 16'd96;  end
            4'b1001: begin info.n_dbps = 16'd96;  info.n_cbps = 16'd192; end
            4'b1101: begin info.n_dbps = 16'd144; info.n_cbps = 16'd192; end
            4'b1000: begin info.n_dbps = 16'd192; info.n_cbps = 16'd288; end
            4'b1100: begin info.n_dbps = 16'd216; info.n_cbps = 16'd288; end
            default: info.valid = 1'b0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/ofdm_rx_decode_ctrl_if.sv
// Front-end / decoder / status signal bundle for the OFDM RX decode controller.
interface ofdm_rx_decode_ctrl_if;
    logic        start;
    logic        abort;
    logic [7:0]  byte_in;
    logic        byte_in_strobe;
    logic        dec_reset;
    logic        dec_enable;
    logic [7:0]  dec_rate;
    logic        dec_do_descramble;
    logic [31:0] dec_num_bits;
    logic        sig_valid;
    logic        sig_error;
    logic [3:0]  pkt_rate;
    logic [11:0] pkt_len;
    logic [11:0] byte_count;
    logic        pkt_done;
    logic        pkt_timeout;
    logic        busy;

    modport master (
        input  start, abort, byte_in, byte_in_strobe,
        output dec_reset, dec_enable, dec_rate, dec_do_descramble, dec_num_bits,
        output sig_valid, sig_error, pkt_rate, pkt_len, byte_count,
        output pkt_done, pkt_timeout, busy
    );

    modport slave (
        output start, abort, byte_in, byte_in_strobe,
        input  dec_reset, dec_enable, dec_rate, dec_do_descramble, dec_num_bits,
        input  sig_valid, sig_error, pkt_rate, pkt_len, byte_count,
        input  pkt_done, pkt_timeout, busy
    );
endinterface

// File: rtl/ofdm_rx_decode_ctrl_nsym.sv
// Iterative symbol-count engine: finds the coded bits covering SERVICE+TAIL+8*len data bits.
module ofdm_nsym_calc
    import ofdm_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        start_i,
    input  logic [11:0] len_i,
    input  logic [15:0] n_dbps_i,
    input  logic [15:0] n_cbps_i,
    output logic        done_o,
    output logic [15:0] coded_bits_o
);

    logic [15:0] target;
    logic [15:0] acc_dbps_q;
    logic [15:0] acc_cbps_q;
    logic        run_q;
    logic        done_q;

    assign target = SERVICE_TAIL_BITS + {1'b0, len_i, 3'b000};

    // Add one symbol per cycle until the data-bit accumulator covers the target.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_dbps_q <= '0;
            acc_cbps_q <= '0;
            run_q      <= 1'b0;
            done_q     <= 1'b0;
        end else if (clr_i || start_i) begin
            acc_dbps_q <= '0;
            acc_cbps_q <= '0;
            run_q      <= start_i && !clr_i;
            done_q     <= 1'b0;
        end else if (run_q) begin
            if (acc_dbps_q >= target) begin
                run_q  <= 1'b0;
                done_q <= 1'b1;
            end else begin
                acc_dbps_q <= acc_dbps_q + n_dbps_i;
                acc_cbps_q <= acc_cbps_q + n_cbps_i;
            end
        end
    end

    assign done_o       = done_q;
    assign coded_bits_o = acc_cbps_q;

endmodule

// File: rtl/ofdm_rx_decode_ctrl.sv
// Sequences the OFDM decoder through SIGNAL decode/check and DATA byte counting.
module ofdm_rx_decode_ctrl
    import ofdm_ctrl_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000,
    parameter logic [31:0] SIG_CODED_BITS = 32'd48
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    ofdm_rx_decode_ctrl_if.master  ctrl
);

    state_e      state_q;
    logic        dec_reset_q, dec_enable_q, dec_desc_q;
    logic [7:0]  dec_rate_q;
    logic [31:0] dec_num_bits_q;
    logic        sig_valid_q, sig_error_q, pkt_done_q, pkt_timeout_q, busy_q;
    logic [3:0]  pkt_rate_q;
    logic [11:0] pkt_len_q, byte_count_q;
    logic [23:0] sig_q;
    logic [1:0]  sig_cnt_q;
    logic [31:0] wdog_q;

    rate_info_t  rinfo;
    logic        sig_ok;
    logic        nsym_done;
    logic [15:0] nsym_bits;
    logic        wdog_exp;

    // One lookup serves both the SIGNAL check and the DATA symbol engine.
    assign rinfo    = rate_lookup((state_q == SIG_CHK) ? sig_q[3:0] : pkt_rate_q);
    assign sig_ok   = (^sig_q[17:0] == 1'b0) && rinfo.valid &&
                      (sig_q[16:5] != '0) && (sig_q[23:18] == '0);
    assign wdog_exp = (wdog_q == TIMEOUT_CYCLES - 32'd1);

    ofdm_nsym_calc u_nsym (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clr_i        (ctrl.abort),
        .start_i      (state_q == DATA_RST),
        .len_i        (pkt_len_q),
        .n_dbps_i     (rinfo.n_dbps),
        .n_cbps_i     (rinfo.n_cbps),
        .done_o       (nsym_done),
        .coded_bits_o (nsym_bits)
    );

    // Main FSM; every output is a register updated alongside the state transition.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            dec_reset_q    <= 1'b1;
            dec_enable_q   <= 1'b0;
            dec_rate_q     <= '0;
            dec_desc_q     <= 1'b0;
            dec_num_bits_q <= '0;
            sig_valid_q    <= 1'b0;
            sig_error_q    <= 1'b0;
            pkt_done_q     <= 1'b0;
            pkt_timeout_q  <= 1'b0;
            busy_q         <= 1'b0;
            pkt_rate_q     <= '0;
            pkt_len_q      <= '0;
            byte_count_q   <= '0;
            sig_q          <= '0;
            sig_cnt_q      <= '0;
            wdog_q         <= '0;
        end else begin
            sig_valid_q   <= 1'b0;
            sig_error_q   <= 1'b0;
            pkt_done_q    <= 1'b0;
            pkt_timeout_q <= 1'b0;
            if (ctrl.abort) begin
                state_q      <= IDLE;
                dec_reset_q  <= 1'b1;
                dec_enable_q <= 1'b0;
                busy_q       <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (ctrl.start) begin
                        state_q        <= SIG_RST;
                        busy_q         <= 1'b1;
                        dec_reset_q    <= 1'b1;
                        dec_enable_q   <= 1'b0;
                        dec_rate_q     <= {4'b0000, RATE_6M};
                        dec_desc_q     <= 1'b0;
                        dec_num_bits_q <= SIG_CODED_BITS;
                        sig_cnt_q      <= '0;
                    end
                    SIG_RST: begin
                        state_q      <= SIG_DEC;
                        dec_reset_q  <= 1'b0;
                        dec_enable_q <= 1'b1;
                        wdog_q       <= '0;
                    end
                    SIG_DEC: if (ctrl.byte_in_strobe) begin
                        sig_q     <= {ctrl.byte_in, sig_q[23:8]};
                        sig_cnt_q <= sig_cnt_q + 2'd1;
                        wdog_q    <= '0;
                        if (sig_cnt_q == 2'd2) state_q <= SIG_CHK;
                    end else if (wdog_exp) begin
                        pkt_timeout_q <= 1'b1;
                        state_q       <= IDLE;
                        dec_reset_q   <= 1'b1;
                        dec_enable_q  <= 1'b0;
                        busy_q        <= 1'b0;
                    end else begin
                        wdog_q <= wdog_q + 32'd1;
                    end
                    SIG_CHK: if (sig_ok) begin
                        sig_valid_q    <= 1'b1;
                        pkt_rate_q     <= sig_q[3:0];
                        pkt_len_q      <= sig_q[16:5];
                        state_q        <= DATA_RST;
                        dec_reset_q    <= 1'b1;
                        dec_rate_q     <= {4'b0000, sig_q[3:0]};
                        dec_desc_q     <= 1'b1;
                        dec_num_bits_q <= '1;
                        byte_count_q   <= '0;
                    end else begin
                        sig_error_q  <= 1'b1;
                        state_q      <= IDLE;
                        dec_reset_q  <= 1'b1;
                        dec_enable_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                    DATA_RST: begin
                        state_q      <= DATA_DEC;
                        dec_reset_q  <= 1'b0;
                        dec_enable_q <= 1'b1;
                        wdog_q       <= '0;
                    end
                    DATA_DEC: begin
                        if (nsym_done) dec_num_bits_q <= {16'h0000, nsym_bits};
                        if (ctrl.byte_in_strobe) begin
                            byte_count_q <= byte_count_q + 12'd1;
                            wdog_q       <= '0;
                            if (byte_count_q + 12'd1 == pkt_len_q) begin
                                pkt_done_q   <= 1'b1;
                                state_q      <= IDLE;
                                dec_reset_q  <= 1'b1;
                                dec_enable_q <= 1'b0;
                                busy_q       <= 1'b0;
                            end
                        end else if (wdog_exp) begin
                            pkt_timeout_q <= 1'b1;
                            state_q       <= IDLE;
                            dec_reset_q   <= 1'b1;
                            dec_enable_q  <= 1'b0;
                            busy_q        <= 1'b0;
                        end else begin
                            wdog_q <= wdog_q + 32'd1;
                        end
                    end
                    default: begin
                        state_q      <= IDLE;
                        dec_reset_q  <= 1'b1;
                        dec_enable_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ctrl.dec_reset         = dec_reset_q;
    assign ctrl.dec_enable        = dec_enable_q;
    assign ctrl.dec_rate          = dec_rate_q;
    assign ctrl.dec_do_descramble = dec_desc_q;
    assign ctrl.dec_num_bits      = dec_num_bits_q;
    assign ctrl.sig_valid         = sig_valid_q;
    assign ctrl.sig_error         = sig_error_q;
    assign ctrl.pkt_rate          = pkt_rate_q;
    assign ctrl.pkt_len           = pkt_len_q;
    assign ctrl.byte_count        = byte_count_q;
    assign ctrl.pkt_done          = pkt_done_q;
    assign ctrl.pkt_timeout       = pkt_timeout_q;
    assign ctrl.busy              = busy_q;

endmodule

// File: tb/tb_ofdm_rx_decode_ctrl.sv
// Directed self-checking bench for ofdm_rx_decode_ctrl.
module tb_ofdm_rx_decode_ctrl;

    localparam int unsigned T = 200;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    ofdm_rx_decode_ctrl_if bus ();

    ofdm_rx_decode_ctrl #(
        .TIMEOUT_CYCLES (32'(T)),
        .SIG_CODED_BITS (32'd48)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .ctrl   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.byte_in        = b;
        bus.byte_in_strobe = 1'b1;
        tick;
        bus.byte_in_strobe = 1'b0;
    endtask

    // start, SIG_RST, SIG_DEC, then the three SIGNAL bytes; ends with the FSM in SIG_CHK
    task automatic send_sig(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        tick;
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
    endtask

    task automatic wait_nsym;
        int unsigned n;
        n = 0;
        while (bus.dec_num_bits === 32'hFFFF_FFFF && n < 400) begin
            tick;
            n++;
        end
        chk("nsym_bound", 32'(n < 400), 1);
    endtask

    logic [23:0] bad_sig [3];
    logic        pulse_seen;

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.byte_in = '0;
        bus.byte_in_strobe = 1'b0;
        bad_sig[0] = 24'h020C8B;   // parity bit flipped
        bad_sig[1] = 24'h020C80;   // rate 0000, parity correct
        bad_sig[2] = 24'h040C8B;   // tail bit set
        rst_n = 1'b0;
        repeat (3) tick;

        chk("rst_dec_reset", 32'(bus.dec_reset), 1);
        chk("rst_dec_enable", 32'(bus.dec_enable), 0);
        chk("rst_dec_rate", 32'(bus.dec_rate), 0);
        chk("rst_num_bits", bus.dec_num_bits, 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_pkt_len", 32'(bus.pkt_len), 0);
        chk("rst_sig_valid", 32'(bus.sig_valid), 0);
        rst_n = 1'b1;
        tick;

        // Packet A: rate 1011, len 100 -> sig = 0x000C8B
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        chk("a_sigrst_busy", 32'(bus.busy), 1);
        chk("a_sigrst_rate", 32'(bus.dec_rate), 'h0B);
        chk("a_sigrst_nbits", bus.dec_num_bits, 48);
        chk("a_sigrst_reset", 32'(bus.dec_reset), 1);
        chk("a_sigrst_desc", 32'(bus.dec_do_descramble), 0);
        tick;
        chk("a_sigdec_reset", 32'(bus.dec_reset), 0);
        chk("a_sigdec_enable", 32'(bus.dec_enable), 1);
        send_byte(8'h8B);
        send_byte(8'h0C);
        send_byte(8'h00);
        tick;
        chk("a_sig_valid", 32'(bus.sig_valid), 1);
        chk("a_sig_error", 32'(bus.sig_error), 0);
        chk("a_pkt_len", 32'(bus.pkt_len), 100);
        chk("a_pkt_rate", 32'(bus.pkt_rate), 'hB);
        chk("a_datarst_rate", 32'(bus.dec_rate), 'h0B);
        chk("a_datarst_desc", 32'(bus.dec_do_descramble), 1);
        chk("a_datarst_nbits", bus.dec_num_bits, 32'hFFFF_FFFF);
        chk("a_datarst_reset", 32'(bus.dec_reset), 1);
        tick;
        chk("a_valid_pulse", 32'(bus.sig_valid), 0);
        chk("a_datadec_reset", 32'(bus.dec_reset), 0);
        wait_nsym;
        chk("a_nbits", bus.dec_num_bits, 1680);
        for (int i = 0; i < 99; i++) send_byte(8'(i));
        chk("a_count99", 32'(bus.byte_count), 99);
        chk("a_done_early", 32'(bus.pkt_done), 0);
        send_byte(8'h63);
        chk("a_done", 32'(bus.pkt_done), 1);
        chk("a_count100", 32'(bus.byte_count), 100);
        chk("a_idle_busy", 32'(bus.busy), 0);
        chk("a_idle_reset", 32'(bus.dec_reset), 1);
        send_byte(8'hAA);
        chk("a_done_pulse", 32'(bus.pkt_done), 0);
        chk("a_extra_ignored", 32'(bus.byte_count), 100);

        // Packet B: rate 1100, len 4095 -> sig = 0x01FFEC; reset mid DATA_DEC
        send_sig(8'hEC, 8'hFF, 8'h01);
        tick;
        chk("b_sig_valid", 32'(bus.sig_valid), 1);
        chk("b_pkt_len", 32'(bus.pkt_len), 4095);
        chk("b_dec_rate", 32'(bus.dec_rate), 'h0C);
        tick;
        wait_nsym;
        chk("b_nbits", bus.dec_num_bits, 43776);
        for (int i = 0; i < 10; i++) send_byte(8'(i));
        chk("b_count10", 32'(bus.byte_count), 10);
        #2 rst_n = 1'b0;
        #1;
        chk("b_rst_busy", 32'(bus.busy), 0);
        chk("b_rst_reset", 32'(bus.dec_reset), 1);
        chk("b_rst_enable", 32'(bus.dec_enable), 0);
        chk("b_rst_rate", 32'(bus.dec_rate), 0);
        chk("b_rst_desc", 32'(bus.dec_do_descramble), 0);
        chk("b_rst_nbits", bus.dec_num_bits, 0);
        chk("b_rst_count", 32'(bus.byte_count), 0);
        chk("b_rst_len", 32'(bus.pkt_len), 0);
        chk("b_rst_prate", 32'(bus.pkt_rate), 0);
        tick;
        rst_n = 1'b1;
        tick;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        chk("b_restart_busy", 32'(bus.busy), 1);
        chk("b_restart_rate", 32'(bus.dec_rate), 'h0B);
        chk("b_restart_nbits", bus.dec_num_bits, 48);
        bus.abort = 1'b1;
        tick;
        bus.abort = 1'b0;
        chk("b_abort_busy", 32'(bus.busy), 0);

        // SIGNAL errors: parity, bad rate, tail
        for (int i = 0; i < 3; i++) begin
            send_sig(bad_sig[i][7:0], bad_sig[i][15:8], bad_sig[i][23:16]);
            tick;
            chk($sformatf("err%0d_sig_error", i), 32'(bus.sig_error), 1);
            chk($sformatf("err%0d_sig_valid", i), 32'(bus.sig_valid), 0);
            chk($sformatf("err%0d_busy", i), 32'(bus.busy), 0);
            chk($sformatf("err%0d_reset", i), 32'(bus.dec_reset), 1);
            tick;
            chk($sformatf("err%0d_pulse", i), 32'(bus.sig_error), 0);
        end

        // Timeout: rate 1011, len 50 -> sig = 0x00064B, 20 bytes then silence
        send_sig(8'h4B, 8'h06, 8'h00);
        tick;
        chk("t_sig_valid", 32'(bus.sig_valid), 1);
        tick;
        for (int i = 0; i < 20; i++) send_byte(8'(i));
        repeat (T - 1) tick;
        chk("t_not_yet", 32'(bus.pkt_timeout), 0);
        chk("t_busy_before", 32'(bus.busy), 1);
        tick;
        chk("t_timeout", 32'(bus.pkt_timeout), 1);
        chk("t_count", 32'(bus.byte_count), 20);
        chk("t_busy_after", 32'(bus.busy), 0);
        chk("t_no_done", 32'(bus.pkt_done), 0);

        // Abort in DATA_DEC with a coincident strobe; start there is ignored
        send_sig(8'h8B, 8'h0C, 8'h00);
        tick;
        tick;
        for (int i = 0; i < 5; i++) send_byte(8'(i));
        chk("x_count5", 32'(bus.byte_count), 5);
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        chk("x_start_busy", 32'(bus.busy), 1);
        chk("x_start_enable", 32'(bus.dec_enable), 1);
        chk("x_start_reset", 32'(bus.dec_reset), 0);
        bus.abort = 1'b1;
        bus.byte_in = 8'h55;
        bus.byte_in_strobe = 1'b1;
        tick;
        bus.abort = 1'b0;
        bus.byte_in_strobe = 1'b0;
        chk("x_abort_busy", 32'(bus.busy), 0);
        chk("x_abort_done", 32'(bus.pkt_done), 0);
        chk("x_abort_timeout", 32'(bus.pkt_timeout), 0);
        chk("x_abort_reset", 32'(bus.dec_reset), 1);
        pulse_seen = 1'b0;
        for (int i = 0; i < int'(T) + 5; i++) begin
            tick;
            if (bus.pkt_done || bus.pkt_timeout || bus.sig_valid || bus.sig_error)
                pulse_seen = 1'b1;
        end
        chk("x_quiet_after_abort", 32'(pulse_seen), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
